// File: rtl/mul_fu_arbiter.sv
// Round-robin arbiter/sequencer sharing one non-pipelined multiplier among
// several reservation stations, with flush handling and a stuck-unit watchdog.
module mul_fu_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*32-1:0]    req_a,
    input  logic [N_REQ*32-1:0]    req_b,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   flush,
    output logic                   fu_en,
    output logic [31:0]            fu_a,
    output logic [31:0]            fu_b,
    input  logic [31:0]            fu_res,
    input  logic                   fu_finish,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [31:0]            cdb_data,
    input  logic                   cdb_ready,
    output logic                   busy,
    output logic                   err
);
    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               win_found;
    int unsigned        idx;
    logic               grant_c;
    logic [31:0]        a_sel, b_sel;
    logic [TAG_W-1:0]   tag_sel;
    logic [CNT_W-1:0]   cnt_q, cnt_inc;
    logic               timeout;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        data_q;
    logic               err_q;

    // Round-robin search starting one past the last granted index
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % N_REQ;
            cand = PTR_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        tag_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == PTR_W'(i)) begin
                a_sel   = req_a[i*32 +: 32];
                b_sel   = req_b[i*32 +: 32];
                tag_sel = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign grant_c = (state_q == S_IDLE) && win_found && !flush;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and combinational launch/grant outputs
    always_comb begin
        state_d = state_q;
        fu_en   = 1'b0;
        timeout = 1'b0;
        gnt     = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    gnt     = N_REQ'(1) << win_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    fu_en   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fu_finish) begin
                    state_d = flush ? S_IDLE : S_RESULT;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESULT: begin
                if (flush || cdb_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (fu_finish) begin
                    state_d = S_IDLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            fu_a    <= '0;
            fu_b    <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                ptr_q <= win_idx;
                fu_a  <= a_sel;
                fu_b  <= b_sel;
                tag_q <= tag_sel;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT || state_q == S_DRAIN) begin
                cnt_q <= cnt_inc;
            end
            if (state_q == S_WAIT && fu_finish && !flush) data_q <= fu_res;
            if (timeout) err_q <= 1'b1;
        end
    end

    // A flushed result is withdrawn in the same cycle so it is never consumed
    assign cdb_valid = (state_q == S_RESULT) && !flush;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mul_fu_arbiter.sv
// Directed bench for mul_fu_arbiter with a 7-cycle-latency multiplier model.
module tb_mul_fu_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned TAG_W = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*32-1:0]    req_a, req_b;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]       gnt;
    logic                   flush;
    logic                   fu_en;
    logic [31:0]            fu_a, fu_b, fu_res;
    logic                   fu_finish;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [31:0]            cdb_data;
    logic                   cdb_ready;
    logic                   busy, err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2:0]  m_cnt;
    logic [31:0] m_prod;
    logic        stall;

    mul_fu_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .gnt(gnt), .flush(flush), .fu_en(fu_en),
        .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res), .fu_finish(fu_finish),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_ready(cdb_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Multiplier model: finish pulse 7 cycles after the enable cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= '0;
            m_prod <= '0;
        end else if (fu_en) begin
            m_cnt  <= 3'd1;
            m_prod <= fu_a * fu_b;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= (m_cnt == 3'd7) ? 3'd0 : m_cnt + 3'd1;
        end
    end
    assign fu_finish = (m_cnt == 3'd7) && !stall;
    assign fu_res    = m_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
        req_a[i*32 +: 32]         = a;
        req_b[i*32 +: 32]         = b;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!cdb_valid && n < budget) begin
            next_cycle();
            #1;
            n++;
        end
        check(tag, 32'(cdb_valid), 1);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_tag = '0;
        flush = 1'b0; cdb_ready = 1'b1; stall = 1'b0;

        // Reset values
        repeat (2) next_cycle();
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_fu_en", 32'(fu_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(cdb_valid), 0);
        check("rst_err", 32'(err), 0);
        next_cycle();
        rst_n = 1'b1;

        // Single op on requester 2
        next_cycle();
        set_op(2, 7, 6, 5);
        req = 4'b0100;
        #1 check("t1_gnt", 32'(gnt), 4);
        next_cycle();
        req = '0;
        #1;
        check("t1_fu_en", 32'(fu_en), 1);
        check("t1_fu_a", fu_a, 7);
        check("t1_fu_b", fu_b, 6);
        for (int c = 2; c <= 8; c++) begin
            next_cycle();
            #1;
            check("t1_wait_en", 32'(fu_en), 0);
            check("t1_wait_valid", 32'(cdb_valid), 0);
        end
        next_cycle();
        #1;
        check("t1_valid", 32'(cdb_valid), 1);
        check("t1_data", cdb_data, 42);
        check("t1_tag", 32'(cdb_tag), 5);
        next_cycle();
        #1;
        check("t1_idle", 32'(busy), 0);

        // Fairness from a fresh pointer
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 2), 32'(i + 3), TAG_W'(i));
        next_cycle();
        req = 4'hF;
        for (int c = 0; c < 50; c++) begin
            int k;
            if (c > 0) next_cycle();
            #1;
            k = (c / 10) % 4;
            if (c % 10 == 0) check("rr_gnt", 32'(gnt), 32'(1) << k);
            else check("rr_no_gnt", 32'(gnt), 0);
            if (c % 10 == 9) begin
                check("rr_valid", 32'(cdb_valid), 1);
                check("rr_data", cdb_data, 32'((k + 2) * (k + 3)));
                check("rr_tag", 32'(cdb_tag), 32'(k));
            end
        end
        next_cycle();
        req = '0;
        #1;
        check("rr_end_gnt", 32'(gnt), 0);
        check("rr_end_busy", 32'(busy), 0);

        // Backpressure with requester 3 left pending
        next_cycle();
        set_op(1, 100, 3, 1);
        req = 4'b1010;
        cdb_ready = 1'b0;
        #1 check("bp_gnt", 32'(gnt), 2);
        next_cycle();
        req = 4'b1000;
        for (int c = 2; c <= 8; c++) next_cycle();
        for (int c = 9; c <= 13; c++) begin
            next_cycle();
            #1;
            check("bp_valid", 32'(cdb_valid), 1);
            check("bp_data", cdb_data, 300);
            check("bp_tag", 32'(cdb_tag), 1);
            check("bp_no_gnt", 32'(gnt), 0);
        end
        next_cycle();
        cdb_ready = 1'b1;
        #1;
        check("bp_last_valid", 32'(cdb_valid), 1);
        check("bp_last_gnt", 32'(gnt), 0);
        next_cycle();
        #1;
        check("bp_idle", 32'(busy), 0);
        check("bp_next_gnt", 32'(gnt), 8);

        // Flush in WAIT at cycle 4 of the op granted above
        next_cycle();
        req = '0;
        #1 check("fl_fu_en", 32'(fu_en), 1);
        next_cycle();
        next_cycle();
        next_cycle();
        flush = 1'b1;
        #1 check("fl_busy", 32'(busy), 1);
        next_cycle();
        flush = 1'b0;
        #1 check("fl_drain_en", 32'(fu_en), 0);
        for (int c = 5; c <= 8; c++) begin
            if (c > 5) next_cycle();
            #1;
            check("fl_drain_busy", 32'(busy), 1);
            check("fl_no_valid", 32'(cdb_valid), 0);
        end
        next_cycle();
        req = 4'b0001;
        #1;
        check("fl_idle", 32'(busy), 0);
        check("fl_no_valid9", 32'(cdb_valid), 0);
        check("fl_gnt9", 32'(gnt), 1);
        next_cycle();
        req = '0;
        #1;
        check("fl2_fu_en", 32'(fu_en), 1);
        check("fl2_fu_a", fu_a, 2);
        wait_valid("fl2_wait_valid", 20);
        check("fl2_data", cdb_data, 6);
        next_cycle();
        #1 check("fl2_idle", 32'(busy), 0);

        // Flush in IDLE, then flush in ISSUE
        next_cycle();
        req = 4'b0100;
        flush = 1'b1;
        #1 check("fi_no_gnt", 32'(gnt), 0);
        next_cycle();
        #1 check("fi_still_idle", 32'(busy), 0);
        flush = 1'b0;
        #1 check("fs_gnt", 32'(gnt), 4);
        next_cycle();
        req = '0;
        flush = 1'b1;
        #1 check("fs_no_launch", 32'(fu_en), 0);
        next_cycle();
        flush = 1'b0;
        #1 check("fs_idle", 32'(busy), 0);

        // Watchdog with a stuck unit
        next_cycle();
        stall = 1'b1;
        req = 4'b0010;
        #1 check("wd_gnt", 32'(gnt), 2);
        next_cycle();
        req = '0;
        for (int c = 2; c <= 17; c++) next_cycle();
        #1;
        check("wd_err_pre", 32'(err), 0);
        check("wd_busy_pre", 32'(busy), 1);
        next_cycle();
        #1;
        check("wd_err", 32'(err), 1);
        check("wd_idle", 32'(busy), 0);
        stall = 1'b0;
        set_op(2, 9, 9, 4);
        next_cycle();
        req = 4'b0100;
        #1 check("wd2_gnt", 32'(gnt), 4);
        next_cycle();
        req = '0;
        wait_valid("wd2_wait_valid", 20);
        check("wd2_data", cdb_data, 81);
        check("wd_err_sticky", 32'(err), 1);
        next_cycle();

        // Asynchronous reset in the middle of WAIT
        next_cycle();
        req = 4'b1000;
        #1 check("ar_gnt", 32'(gnt), 8);
        next_cycle();
        req = '0;
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_err", 32'(err), 0);
        check("ar_fu_a", fu_a, 0);
        check("ar_fu_b", fu_b, 0);
        check("ar_data", cdb_data, 0);
        check("ar_tag", 32'(cdb_tag), 0);
        check("ar_valid", 32'(cdb_valid), 0);
        check("ar_fu_en", 32'(fu_en), 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_fu_arbiter.md
# mul_fu_arbiter

Round-robin arbiter and sequencer that shares the single non-pipelined multiplier functional unit among several reservation-station requesters. It grants one operand pair at a time and launches it with a one-cycle enable. It waits for the unit's finish pulse and returns the tagged product on a result bus with backpressure. It sits between the multiply reservation stations and the multiplier unit and also handles pipeline flush and a stuck-unit watchdog.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TAG_W, 3: destination tag width.
- TIMEOUT, 16: max cycles in WAIT/DRAIN before the watchdog fires.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  request vector; requester i holds req[i] and its operands stable until granted.
- req_a, req_b  in  N_REQ*32  operands; slice i = [32*i+31:32*i].
- req_tag  in  N_REQ*TAG_W  destination tags, sliced likewise.
- gnt  out  N_REQ  one-hot, combinational, asserted only in IDLE; the operation is accepted at that edge.
- flush  in  1  synchronous kill of any accepted/in-flight operation.
- fu_en  out  1  one-cycle launch pulse to the multiplier.
- fu_a, fu_b  out  32  latched operands, valid while fu_en=1.
- fu_res  in  32  product, sampled when fu_finish=1.
- fu_finish  in  1  completion pulse from the multiplier.
- cdb_valid  out  1  result valid.
- cdb_tag  out  TAG_W, cdb_data  out  32  result tag/data.
- cdb_ready  in  1  result consumed when cdb_valid & cdb_ready.
- busy  out  1  state != IDLE.
- err  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESULT, DRAIN.
- IDLE: if |req and !flush, grant winner, latch a/b/tag, go to ISSUE. Otherwise stay.
- Round-robin: priority starts at index ptr+1 mod N_REQ. After each grant, ptr = granted index. Reset ptr = N_REQ-1, so req[0] has top priority first.
- ISSUE: fu_en=1, go to WAIT, clear watchdog counter. If flush: fu_en=0, go to IDLE, nothing launched.
- WAIT: on fu_finish, latch fu_res into cdb_data and go to RESULT. If flush (and no fu_finish the same cycle), go to DRAIN. If fu_finish and flush coincide, discard the result and go to IDLE.
- RESULT: cdb_valid=1, and cdb_tag/cdb_data are held stable until cdb_ready. Then go to IDLE. If flush, drop valid and go to IDLE.
- DRAIN: the unit cannot be aborted, so wait for fu_finish, discard the result, and go to IDLE. No grant is issued meanwhile.
- Watchdog: the counter increments each cycle in WAIT/DRAIN. When it reaches TIMEOUT without fu_finish: set err, abandon the operation, go to IDLE.
- fu_en is never asserted outside ISSUE. ISSUE is reachable only from IDLE, which guarantees at least one idle cycle after fu_finish before the next launch. The unit accepts a new enable only after its internal state returns to zero.
- Reset values: state=IDLE, gnt=0, fu_en=0, fu_a=fu_b=0, cdb_valid=0, cdb_tag=0, cdb_data=0, busy=0, err=0, counter=0.

## Timing
- Unit latency: fu_finish rises 7 cycles after the fu_en cycle.
- Request seen in IDLE at cycle 0: gnt at cycle 0, fu_en at cycle 1, fu_finish at cycle 8, cdb_valid at cycle 9.
- With cdb_ready=1 at cycle 9: IDLE at cycle 10, next gnt at cycle 10, next fu_en at cycle 11.
- Back-to-back throughput: one operation per 10 cycles, plus any backpressure cycles in RESULT.
- Flush effect:
  - Flush at cycle 0 (IDLE): no grant.
  - Flush at cycle 1: no launch.
  - Flush at cycles 2–7: DRAIN until finish at cycle 8, then IDLE at cycle 9.
- Reset mid-operation returns to IDLE immediately. The environment resets the multiplier on the same reset.

## Test plan
- Single op: req[2]=1, a=7, b=6, tag=5 → gnt=0100 at cycle 0, fu_en at cycle 1 with fu_a=7, fu_b=6, cdb_valid at cycle 9 with data=42, tag=5.
- Fairness: req=1111 held continuously with cdb_ready=1 → grants in order 0,1,2,3,0, each 10 cycles apart. No requester is granted twice before all others are served.
- Backpressure: cdb_ready=0 for 5 cycles after cdb_valid → data/tag stable, no new gnt. Ready at the 6th cycle → IDLE the next cycle.
- Flush in WAIT at cycle 4 → DRAIN, finish at cycle 8 discarded, cdb_valid never asserts, gnt possible at cycle 9.
- Watchdog: model holds fu_finish=0 → err=1 after TIMEOUT=16 WAIT cycles, return to IDLE, err stays 1 until rst_n=0.
- Async reset asserted mid-WAIT → all outputs return to their reset values immediately, without waiting for a clock edge.
